// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_VALUE     = 4'd3;

  // Number of decimal digits needed to represent 2^n - 1.
  function automatic int bcd_min_digits(input int n);
    longint unsigned v;
    int d;
    v = (64'd1 << n) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_digito_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digito_add3
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= ADD3_THRESHOLD) ? (digit_in + ADD3_VALUE) : digit_in;

endmodule

// File: rtl/bcd_secuencial.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// with a start/busy/done handshake and a result held until the next conversion.
module bcd_secuencial
  import bcd_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int BCD_W = 4 * DIGITS;

  if (DIGITS < bcd_min_digits(N)) begin : g_digits_check
    $fatal(1, "bcd_secuencial: DIGITS=%0d too small for N=%0d", DIGITS, N);
  end

  state_t             state_q, state_d;
  logic [N-1:0]       bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   corr;
  logic [BCD_W+N-1:0] cat_sh;
  logic [BCD_W-1:0]   scratch_nx;
  logic [N-1:0]       bin_nx;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_digito_add3 u_add3 (
      .digit_in  (scratch[4*k +: 4]),
      .digit_out (corr[4*k +: 4])
    );
  end

  // Correction happens on the pre-shift digits; the shift then pulls in the next binary MSB.
  assign cat_sh     = {corr, bin_sr} << 1;
  assign scratch_nx = cat_sh[BCD_W+N-1:N];
  assign bin_nx     = cat_sh[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= CNT_W'(N - 1);
          end
        end
        SHIFT: begin
          scratch <= scratch_nx;
          bin_sr  <= bin_nx;
          if (cnt == '0) bcd_out <= scratch_nx;
          else           cnt     <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_secuencial.sv
// Self-checking bench for bcd_secuencial: vector table, corner-case sequences and random scoreboard.
module tb_bcd_secuencial;

  localparam int N      = 10;
  localparam int DIGITS = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [N-1:0]      bin_in;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd_out;

  int checks   = 0;
  int failures = 0;
  int done_count = 0;
  int cycle = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int unsigned bin;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  bcd_secuencial #(.N(N), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bcd_out), 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        for (int k = 0; k < DIGITS; k++)
          check($sformatf("digit%0d", k), 32'(bcd_out[4*k +: 4]), 32'(e[4*k +: 4]));
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  // Single start pulse; verifies busy length and done position relative to acceptance.
  task automatic run_conv(input int unsigned v, input logic [15:0] e);
    int busy_cycles, done_cycles, done_at;
    @(negedge clk);
    bin_in = N'(v);
    start  = 1'b1;
    exp_q.push_back(e);
    busy_cycles = 0;
    done_cycles = 0;
    done_at     = 0;
    for (int j = 1; j <= N + 2; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        done_at = j;
      end
    end
    check($sformatf("busy_len_%0d", v), 32'(busy_cycles), 32'(N + 1));
    check($sformatf("done_cnt_%0d", v), 32'(done_cycles), 32'd1);
    check($sformatf("done_pos_%0d", v), 32'(done_at), 32'(N + 1));
  endtask

  task automatic wait_done(output int stamp);
    bit seen;
    seen = 0;
    stamp = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1;
        stamp = cycle;
      end
    end
    if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, t2, dc;
    vecs[0] = '{1023, 16'h1023};
    vecs[1] = '{0,    16'h0000};
    vecs[2] = '{999,  16'h0999};
    vecs[3] = '{512,  16'h0512};
    vecs[4] = '{9,    16'h0009};

    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_bcd_out", 32'(bcd_out), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end

    // Table-driven single conversions
    for (int i = 0; i < 5; i++) run_conv(vecs[i].bin, vecs[i].exp);
    check("hold_after_conv", 32'(bcd_out), 32'h0009);

    // Start during SHIFT is ignored
    @(negedge clk);
    bin_in = 10'd645;
    start  = 1'b1;
    exp_q.push_back(16'h0645);
    dc = done_count;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = 10'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 6) @(negedge clk);
    check("ignored_start_dones", 32'(done_count - dc), 32'd1);
    check("ignored_start_result", 32'(bcd_out), 32'h0645);

    // Start held high: back-to-back conversions, bin_in change affects only the next one
    @(negedge clk);
    bin_in = 10'd100;
    start  = 1'b1;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0037);
    wait_done(t0);
    repeat (5) @(negedge clk);
    bin_in = 10'd37;
    wait_done(t1);
    check("held_second_result", 32'(bcd_out), 32'h0100);
    wait_done(t2);
    start = 1'b0;
    check("held_third_result", 32'(bcd_out), 32'h0037);
    check("held_period_1", 32'(t1 - t0), 32'(N + 2));
    check("held_period_2", 32'(t2 - t1), 32'(N + 2));
    repeat (3) @(negedge clk);
    check("held_stop_busy", 32'(busy), 32'd0);

    // Reset mid-conversion aborts without touching bcd_out except clearing it
    @(negedge clk);
    bin_in = 10'd1023;
    start  = 1'b1;
    dc = done_count;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd_out", 32'(bcd_out), 32'h0);
    repeat (N + 4) @(negedge clk);
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    check("abort_bcd_hold", 32'(bcd_out), 32'h0);
    run_conv(58, 16'h0058);

    // Random conversions against the decimal model
    for (int i = 0; i < 10; i++) begin
      int unsigned v;
      v = $urandom_range(0, 1023);
      run_conv(v, model_bcd(v));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
